// File: rtl/adda_capture_sequencer.sv
// J2 ADC/DAC sequencer: divided conversion clocks, DAC passthrough, triggered capture buffer and stream readout.
// Optional build macro ADDA_FORCE_TRIG_EN adds i_force_trig to force a trigger while armed.
module adda_capture_sequencer #(
    parameter int DIV_W      = 8,
    parameter int DEPTH_LOG2 = 6,
    parameter int DATA_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DIV_W-1:0]  i_div,
    input  logic              i_arm,
    input  logic [DATA_W-1:0] i_trig_level,
    input  logic [DATA_W-1:0] i_ad_data,
`ifdef ADDA_FORCE_TRIG_EN
    input  logic              i_force_trig,
`endif
    output logic              o_ad_clk,
    output logic              o_da_clk,
    output logic [DATA_W-1:0] o_da_data,
    output logic [1:0]        o_state,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;
    localparam int         DEPTH      = 1 << DEPTH_LOG2;

    logic [DIV_W-1:0]      period;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  tick, ad_clk_d;
    logic                  ad_clk_q, da_clk_q;
    logic [DATA_W-1:0]     sample_q, prev_q, da_data_q;
    logic                  sample_vld_q;
    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, wr_addr;
    logic                  wr_en;
    logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic                  rd_valid_q, rd_valid_d, rd_fetch;
    logic [DATA_W-1:0]     rd_data_q;
    logic                  level_trig, force_hit, trig;
    logic [DATA_W-1:0]     mem [DEPTH];

    // A period below 2 is clamped; the >= wrap recovers if i_div shrinks under the running count.
    assign period    = (i_div == '0) ? DIV_W'(1) : i_div;
    assign tick      = (div_cnt_q >= period);
    assign div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    assign ad_clk_d  = (div_cnt_d <= (period >> 1));

    assign level_trig = (prev_q < i_trig_level) && (sample_q >= i_trig_level);
    assign trig       = level_trig | force_hit;

`ifdef ADDA_FORCE_TRIG_EN
    logic force_pend_q, force_pend_d;

    assign force_hit    = force_pend_q | i_force_trig;
    assign force_pend_d = (state_q == ST_ARMED && state_d == ST_ARMED) ? force_hit : 1'b0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) force_pend_q <= 1'b0;
        else          force_pend_q <= force_pend_d;
    end
`else
    assign force_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_fetch   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_arm) begin
                    state_d  = ST_ARMED;
                    wr_ptr_d = '0;
                end
            end
            ST_ARMED: begin
                if (i_arm) begin
                    wr_ptr_d = '0;
                end else if (sample_vld_q && trig) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    wr_ptr_d = DEPTH_LOG2'(1);
                    state_d  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (i_arm) begin
                    state_d  = ST_ARMED;
                    wr_ptr_d = '0;
                end else if (sample_vld_q) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
                    if (wr_ptr_q == '1) state_d = ST_DONE;
                end
            end
            default: begin
                // First DONE cycle prefetches entry 0; rd_ptr bit DEPTH_LOG2 marks all entries fetched.
                if (!rd_valid_q) begin
                    rd_fetch   = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_ptr_d   = (DEPTH_LOG2 + 1)'(1);
                end else if (i_rd_ready) begin
                    if (rd_ptr_q[DEPTH_LOG2]) begin
                        rd_valid_d = 1'b0;
                        rd_ptr_d   = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        rd_fetch = 1'b1;
                        rd_ptr_d = rd_ptr_q + (DEPTH_LOG2 + 1)'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt_q    <= '0;
            ad_clk_q     <= 1'b0;
            da_clk_q     <= 1'b1;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            prev_q       <= '0;
            da_data_q    <= '0;
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            ad_clk_q     <= ad_clk_d;
            da_clk_q     <= ~ad_clk_d;
            sample_vld_q <= tick;
            if (tick) sample_q <= i_ad_data;
            if (sample_vld_q) begin
                prev_q    <= sample_q;
                da_data_q <= sample_q;
            end
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            if (rd_fetch) rd_data_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
        end
    end

    // NOTE: the buffer has no reset; it is always fully written before DONE lets it be read.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_addr] <= sample_q;
    end

    assign o_ad_clk   = ad_clk_q;
    assign o_da_clk   = da_clk_q;
    assign o_da_data  = da_data_q;
    assign o_state    = state_q;
    assign o_done     = (state_q == ST_DONE);
    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;

endmodule

// File: doc/adda_capture_sequencer.md
Name: adda_capture_sequencer

Overview:
Sequences the J2 ADC/DAC pair from the 25 MHz system clock. Generates divided AD/DA conversion clocks and samples the 8-bit ADC bus once per sample period. Mirrors each sample to the DAC and runs an arm/trigger/capture state machine into an on-chip buffer, which is then drained over a valid/ready stream. Sits between the board top level (J2 pins, buttons, LEDs) and any downstream consumer of the captured samples.

Parameters:
DIV_W, 8, width of sample-period divider input
DEPTH_LOG2, 6, log2 of capture buffer depth (64 samples)
DATA_W, 8, ADC/DAC sample width

Ports:
i_clk  input  1  system clock (clk_25mhz)
i_rst_n  input  1  asynchronous active-low reset
i_div  input  DIV_W  sample period minus 1, in clocks; values 0 and 1 both mean period 2
i_arm  input  1  one-cycle pulse; arms a capture
i_trig_level  input  DATA_W  rising-edge trigger threshold
i_ad_data  input  DATA_W  ADC output bus (J2_AD_PORT)
o_ad_clk  output  1  ADC conversion clock
o_da_clk  output  1  DAC clock, inverse of o_ad_clk
o_da_data  output  DATA_W  DAC input bus (J2_DA_PORT)
o_state  output  2  0=IDLE, 1=ARMED, 2=CAPTURE, 3=DONE
o_done  output  1  high while in DONE
o_rd_data  output  DATA_W  readout sample
o_rd_valid  output  1  readout valid
i_rd_ready  input  1  readout ready

Behaviour:
- Reset (async, i_rst_n=0): div_cnt=0, o_ad_clk=0, o_da_clk=1, o_da_data=0, prev sample=0, state=IDLE, o_done=0, o_rd_valid=0, o_rd_data=0, write and read pointers=0.
- Divider: P=max(i_div,1). div_cnt runs 0..P, then wraps to 0. Wrap condition is div_cnt>=P, so an i_div change takes effect at most one period late and never hangs.
- o_ad_clk (registered): 1 when div_cnt<=(P>>1), else 0. o_da_clk is always the registered complement of o_ad_clk. No combinational path from i_clk.
- Sample tick: the cycle in which div_cnt==P. On that edge i_ad_data is registered into the sample register. One cycle later, o_da_data takes the sample value (passthrough). This is a fixed 1-cycle latency, independent of state.
- FSM, evaluated on the cycle after each tick (sample valid):
  - IDLE: on i_arm go to ARMED with wr_ptr=0.
  - ARMED: trigger when prev<i_trig_level and sample>=i_trig_level. On trigger, write the sample to buf[0], set wr_ptr=1, go to CAPTURE.
  - CAPTURE: write each sample to buf[wr_ptr] and increment. The write at index 2^DEPTH_LOG2-1 moves to DONE.
  - DONE: o_done=1. Read out buf[0..2^DEPTH_LOG2-1] in order. After the last handshake, go to IDLE and drop o_done in the same cycle.
- prev is updated on every sample in all states, so arming on a signal already above threshold waits for a fresh rising crossing.
- i_arm in ARMED or CAPTURE restarts the capture: go to ARMED, wr_ptr=0, partial data discarded. i_arm in DONE is ignored.
- i_arm coinciding with a sample-valid cycle in IDLE: arm takes effect, and that same sample is not tested for trigger.
- Readout:
  - Synchronous buffer read. o_rd_valid rises 1 cycle after entering DONE (prefetch).
  - Transfer occurs when o_rd_valid and i_rd_ready are both 1.
  - o_rd_data and o_rd_valid hold stable while i_rd_ready=0.
  - Back-to-back transfers at 1 per clock when ready stays high.
- Sample ticks during DONE still update o_da_data and prev but never write the buffer.
- Reset mid-operation returns everything to reset values immediately. Buffer contents are undefined but never read before the next capture.

Optional Feature:
ADDA_FORCE_TRIG_EN.
- Defined: adds input i_force_trig (1 bit). In ARMED, i_force_trig=1 on any cycle forces a trigger at the next sample-valid cycle regardless of level. The pending force clears on trigger or on leaving ARMED.
- Undefined: the port is absent and only the level trigger exists.

Test Plan:
- Reset, i_div=3 -> o_ad_clk high for div_cnt 0..1 and low for 2..3 (period 4). o_da_clk is its exact complement. All outputs at reset values while i_rst_n=0.
- i_div=0 and i_div=1 -> both give period-2 clocks. Changing i_div from 9 to 2 while div_cnt=7 -> wrap occurs next cycle, no stall.
- Ramp i_ad_data 0,4,8,... one step per tick, i_div=1 -> o_da_data equals each value 1 cycle after its tick.
- i_trig_level=0x80, arm, ramp 0x70..0xFF then 0x00.. -> capture starts at the first sample >=0x80. 64 samples stored, o_state goes 1->2->3, o_done=1.
- Drain with i_rd_ready toggling 1,0,1,... -> 64 transfers in order starting 0x80, data held during stalls. After the last transfer, o_state=0 and o_done=0.
- i_arm during CAPTURE at sample 20 -> return to ARMED, a new trigger is needed, and buffer index 0 holds the new trigger sample.
